pulse_receiver_capture: RTL



---
 rtl/pulse_receiver_pkg.sv | 26 ++
 rtl/pulse_receiver_fifo.sv | 87 ++++++++
 rtl/pulse_receiver_capture.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_receiver_pkg.sv
// ----------------------------------------------------------------------------
// pulse_receiver_pkg
// Shared types and default widths for the pulse receiver capture block.
//   entry_t  : one FIFO entry {level, duration} at the default counter width
//   state_e  : capture FSM state (StIdle, StMeasure)
//   *_DEF    : default parameter values used by the top level
// ----------------------------------------------------------------------------
package pulse_receiver_pkg;

    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned PRESC_W_DEF    = 8;
    localparam int unsigned FILT_LEN_DEF   = 3;

    // Layout of a captured segment: level of the finished segment, then its length in ticks.
    typedef struct packed {
        logic                 level;
        logic [CNT_W_DEF-1:0] duration;
    } entry_t;

    typedef enum logic {
        StIdle    = 1'b0,
        StMeasure = 1'b1
    } state_e;

endpackage

// File: rtl/pulse_receiver_fifo.sv
// ----------------------------------------------------------------------------
// pulse_receiver_fifo
// Synchronous show-ahead FIFO. The head entry is presented on o_head without a
// pop. A push while full is accepted only if a pop happens in the same clock.
// A pop while empty is ignored, and o_head keeps showing the last head value.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_push         write i_push_data (dropped if full and not popping)
//   i_pop          remove head entry (ignored when empty)
//   o_head         head entry (show-ahead)
//   o_empty/o_full occupancy flags
//   o_level        number of entries held
// ----------------------------------------------------------------------------
module pulse_receiver_fifo #(
    parameter int unsigned WIDTH = 17,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_push_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_head,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [WIDTH-1:0] r_hold;

    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic [WIDTH-1:0] w_head;

    assign w_empty   = (r_level == '0);
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty;
    // A pop frees the slot in the same clock, so a full FIFO still accepts a push.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign w_head    = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_hold   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
            // Remember the head so an empty FIFO keeps showing the last value read.
            if (!w_empty) begin
                r_hold <= w_head;
            end
        end
    end

    assign o_head  = w_empty ? r_hold : w_head;
    assign o_empty = w_empty;
    assign o_full  = w_full;
    assign o_level = r_level;

endmodule

// File: rtl/pulse_receiver_capture.sv
// ----------------------------------------------------------------------------
// pulse_receiver_capture
// Measures high/low segment durations of an external pulse train and queues
// them as {level, duration} entries for the CPU to read. A frame starts on the
// first edge leaving the idle level and ends when the line stays idle for
// i_timeout ticks (pulsing o_frame_done). The final idle segment is not queued.
//
// Build option: define PULSE_RECEIVER_GLITCH_FILTER_EN to add a glitch filter
// after the synchronizer; the line level only changes after the synchronized
// input has held a new value for FILT_LEN consecutive clocks.
//
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_en              capture enable (low: FSM idle, counters cleared)
//   i_sig_in          asynchronous pulse input
//   i_idle_level      line level between frames
//   i_prescale        one duration tick every i_prescale+1 clocks
//   i_timeout         idle ticks that end a frame, 0 disables the timeout
//   i_rd_en           pop head entry
//   o_rd_data         head entry {level, duration}, show-ahead
//   o_rd_valid        FIFO not empty
//   o_fifo_level      entries held
//   o_overflow        sticky, an entry was dropped on a full FIFO
//   i_clr_overflow    clears o_overflow (a new overflow in the same clock wins)
//   o_frame_done      one-clock pulse at frame timeout
//   o_busy            high while measuring a frame
// ----------------------------------------------------------------------------
module pulse_receiver_capture
    import pulse_receiver_pkg::*;
#(
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned PRESC_W    = PRESC_W_DEF,
    parameter int unsigned FILT_LEN   = FILT_LEN_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic                          i_sig_in,
    input  logic                          i_idle_level,
    input  logic [PRESC_W-1:0]            i_prescale,
    input  logic [CNT_W-1:0]              i_timeout,
    input  logic                          i_rd_en,
    output logic [CNT_W:0]                o_rd_data,
    output logic                          o_rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    input  logic                          i_clr_overflow,
    output logic                          o_frame_done,
    output logic                          o_busy
);

    // ------------------------------------------------------------------------
    // Input synchronizer (and optional glitch filter)
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic r_sig_d;
    logic w_sig_s;
    logic w_edge;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sig_d <= 1'b0;
        end else begin
            r_sync1 <= i_sig_in;
            r_sync2 <= r_sync1;
            r_sig_d <= w_sig_s;
        end
    end

`ifdef PULSE_RECEIVER_GLITCH_FILTER_EN
    localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

    logic [FC_W-1:0] r_filt_cnt;
    logic            r_sig_filt;

    // r_filt_cnt counts consecutive clocks in which r_sync2 disagrees with the
    // filtered level; any return to agreement restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_filt_cnt <= '0;
            r_sig_filt <= 1'b0;
        end else if (r_sync2 == r_sig_filt) begin
            r_filt_cnt <= '0;
        end else if (r_filt_cnt == FC_W'(FILT_LEN - 1)) begin
            r_filt_cnt <= '0;
            r_sig_filt <= r_sync2;
        end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
        end
    end

    assign w_sig_s = r_sig_filt;
`else
    logic w_unused_filt_len;
    assign w_unused_filt_len = (FILT_LEN != 0);
    assign w_sig_s           = r_sync2;
`endif

    assign w_edge = (w_sig_s != r_sig_d);

    // ------------------------------------------------------------------------
    // Capture FSM and duration counter
    // ------------------------------------------------------------------------
    state_e             r_state;
    state_e             w_state_next;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_next;
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_presc_next;
    logic               r_frame_done;
    logic               w_frame_done_next;
    logic               w_push;
    logic [CNT_W:0]     w_push_data;

    always_comb begin
        w_state_next      = r_state;
        w_count_next      = r_count;
        w_presc_next      = r_presc;
        w_frame_done_next = 1'b0;
        w_push            = 1'b0;

        if (!i_en) begin
            w_state_next = StIdle;
            w_count_next = '0;
            w_presc_next = '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_edge && (w_sig_s != i_idle_level)) begin
                        w_state_next = StMeasure;
                        w_count_next = CNT_W'(1);
                        w_presc_next = '0;
                    end
                end
                StMeasure: begin
                    if (w_edge) begin
                        // Segment finished: r_sig_d still holds its level.
                        w_push       = 1'b1;
                        w_count_next = CNT_W'(1);
                        w_presc_next = '0;
                    end else if ((w_sig_s == i_idle_level) && (i_timeout != '0) &&
                                 (r_count == i_timeout)) begin
                        w_state_next      = StIdle;
                        w_count_next      = '0;
                        w_presc_next      = '0;
                        w_frame_done_next = 1'b1;
                    end else if (r_presc == i_prescale) begin
                        w_presc_next = '0;
                        if (r_count != {CNT_W{1'b1}}) begin
                            w_count_next = r_count + 1'b1;
                        end
                    end else begin
                        w_presc_next = r_presc + 1'b1;
                    end
                end
                default: begin
                    w_state_next = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_count      <= '0;
            r_presc      <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_count      <= w_count_next;
            r_presc      <= w_presc_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign w_push_data = {r_sig_d, r_count};

    // ------------------------------------------------------------------------
    // Entry FIFO and overflow flag
    // ------------------------------------------------------------------------
    logic w_fifo_empty;
    logic w_fifo_full;
    logic w_drop;
    logic r_overflow;

    pulse_receiver_fifo #(
        .WIDTH (CNT_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (i_rd_en),
        .o_head      (o_rd_data),
        .o_empty     (w_fifo_empty),
        .o_full      (w_fifo_full),
        .o_level     (o_fifo_level)
    );

    // A full FIFO that is popped in the same clock still takes the push.
    assign w_drop = w_push && w_fifo_full && !i_rd_en;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (i_clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_rd_valid   = !w_fifo_empty;
    assign o_overflow   = r_overflow;
    assign o_frame_done = r_frame_done;
    assign o_busy       = (r_state == StMeasure);

endmodule
